serial_adder_sub: RTL and testbench

//   Parametrised bit-serial add/subtract unit: one full-adder cell plus a carry

---
 rtl/serial_adder_sub.sv | 70 +++++++
 tb/tb_serial_adder_sub.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial LSB-first add/subtract with start/busy/done handshake
module serial_adder_sub #(
  parameter int WIDTH  = 8,
  parameter bit SUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, co_q, co_d, ov_q, ov_d;
  logic             neg, s, c_nx, run, accept, last;
  always_comb begin
    neg     = sub & SUB_EN;
    run     = state_q == RUN;
    accept  = start && !run;
    last    = run && cnt_q == CW'(WIDTH - 1);
    s       = opa_q[0] ^ opb_q[0] ^ c_q;
    c_nx    = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    opa_d   = accept ? a : run ? opa_q >> 1 : opa_q;
    opb_d   = accept ? (neg ? ~b : b) : run ? opb_q >> 1 : opb_q;
    c_d     = accept ? neg : run ? c_nx : c_q;
    cnt_d   = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    res_d   = run ? {s, res_q[WIDTH-1:1]} : res_q;
    sum_d   = last ? {s, res_q[WIDTH-1:1]} : sum_q;
    co_d    = last ? c_nx : co_q;
    ov_d    = last ? c_q ^ c_nx : ov_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: randomized self-checking bench against an arithmetic reference model
module tb_serial_adder_sub;
  logic clk = 1'b0, reset = 1'b0;
  logic start8 = 1'b0, sub8 = 1'b0, busy8, done8, co8, ov8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start2 = 1'b0, sub2 = 1'b0, busy2, done2, co2, ov2;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_adder_sub #(.WIDTH(8), .SUB_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );
  serial_adder_sub #(.WIDTH(2), .SUB_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2), .overflow(ov2)
  );
  function automatic logic [33:0] ref_op(input longint x, input longint y, input bit s, input int w);
    longint m, sx, sy, sr, ur, um;
    logic co, ov;
    m  = longint'(1) << w;
    sx = x >= m / 2 ? x - m : x;
    sy = y >= m / 2 ? y - m : y;
    sr = s ? sx - sy : sx + sy;
    ur = s ? x - y : x + y;
    co = s ? (x >= y) : (ur >= m);
    ov = sr < -(m / 2) || sr >= m / 2;
    um = ((ur % m) + m) % m;
    return {ov, co, um[31:0]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input bit noise,
                     output int lat, output bit ok, output logic [7:0] rs, output logic rc, output logic rv);
    logic [7:0] s0;
    s0 = sum8;
    ok = 1'b1;
    a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 !== 1'b1 || sum8 !== s0) ok = 1'b0;
      if (noise) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); start8 = 1'($urandom);
      end
      tick();
      lat++;
    end
    start8 = 1'b0;
    if (busy8 !== 1'b0) ok = 1'b0;
    rs = sum8; rc = co8; rv = ov8;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if ({busy8, done8, sum8, co8, ov8} !== 12'd0) begin errors++; $display("FAIL reset8 got %b want 0", {busy8, done8, sum8, co8, ov8}); end
    checks++; if ({busy2, done2, sum2, co2, ov2} !== 6'd0) begin errors++; $display("FAIL reset2 got %b want 0", {busy2, done2, sum2, co2, ov2}); end
  endtask
  task automatic test_directed();
    logic [7:0] xs[5] = '{8'd100, 8'hC8, 8'd100, 8'd5, 8'h80};
    logic [7:0] ys[5] = '{8'd27, 8'h64, 8'd100, 8'd7, 8'h01};
    logic       ss[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] want[5] = '{{2'b00, 8'd127}, {2'b01, 8'h2C}, {2'b10, 8'hC8}, {2'b00, 8'hFE}, {2'b11, 8'h7F}};
    int lat; bit ok; logic [7:0] rs; logic rc, rv;
    for (int i = 0; i < 5; i++) begin
      op8(xs[i], ys[i], ss[i], 1'b0, lat, ok, rs, rc, rv);
      checks++; if ({rv, rc, rs} !== want[i]) begin errors++; $display("FAIL directed%0d result got %h want %h", i, {rv, rc, rs}, want[i]); end
      checks++; if (lat != 8 || !ok) begin errors++; $display("FAIL directed%0d timing got lat=%0d ok=%0d want lat=8 ok=1", i, lat, ok); end
      tick(); tick();
      checks++; if ({done8, busy8, ov8, co8, sum8} !== {2'b00, want[i]}) begin errors++; $display("FAIL directed%0d idle_hold got %h want %h", i, {done8, busy8, ov8, co8, sum8}, want[i]); end
    end
  endtask
  task automatic test_random(input bit noise);
    int lat; bit ok; logic [7:0] rs, x, y; logic rc, rv, s; logic [33:0] e;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
      e = ref_op(longint'(x), longint'(y), s, 8);
      op8(x, y, s, noise, lat, ok, rs, rc, rv);
      checks++; if ({rv, rc, rs} !== {e[33:32], e[7:0]} || lat != 8 || !ok) begin
        errors++; $display("FAIL random noise=%0d %h%s%h got %h lat=%0d ok=%0d want %h", noise, x, s ? "-" : "+", y, {rv, rc, rs}, lat, ok, {e[33:32], e[7:0]});
      end
      if (i % 3 == 0) tick();
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] xs[3], ys[3]; logic ss[3]; logic [33:0] e; int n;
    for (int i = 0; i < 3; i++) begin xs[i] = 8'($urandom); ys[i] = 8'($urandom); ss[i] = 1'($urandom); end
    a8 = xs[0]; b8 = ys[0]; sub8 = ss[0]; start8 = 1'b1;
    tick();
    a8 = xs[1]; b8 = ys[1]; sub8 = ss[1];
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done8 === 1'b1) begin
        e = ref_op(longint'(xs[n]), longint'(ys[n]), ss[n], 8);
        checks++; if ({ov8, co8, sum8} !== {e[33:32], e[7:0]} || k != 8 + 9 * n) begin
          errors++; $display("FAIL b2b op%0d got %h at k=%0d want %h at k=%0d", n, {ov8, co8, sum8}, k, {e[33:32], e[7:0]}, 8 + 9 * n);
        end
        if (n < 2) n++;
        else n = 3;
      end
      if (k == 9) begin a8 = xs[2]; b8 = ys[2]; sub8 = ss[2]; end
      if (k == 18) start8 = 1'b0;
    end
    start8 = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n); end
  endtask
  task automatic test_mid_reset();
    int lat; bit ok; logic [7:0] rs; logic rc, rv; bit seen;
    op8(8'd60, 8'd3, 1'b0, 1'b0, lat, ok, rs, rc, rv);
    a8 = 8'd9; b8 = 8'd4; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({busy8, done8, sum8, co8, ov8} !== 12'd0) begin errors++; $display("FAIL mid_reset got %b want 0", {busy8, done8, sum8, co8, ov8}); end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL mid_reset_quiet got activity want none"); end
    op8(8'd200, 8'd201, 1'b1, 1'b0, lat, ok, rs, rc, rv);
    checks++; if ({rv, rc, rs} !== {2'b00, 8'hFF} || lat != 8 || !ok) begin errors++; $display("FAIL mid_reset_after got %h lat=%0d want 0ff lat=8", {rv, rc, rs}, lat); end
  endtask
  task automatic test_width2();
    logic [33:0] e; int lat;
    for (int i = 0; i < 10; i++) begin
      a2 = i == 0 ? 2'b11 : 2'($urandom);
      b2 = i == 0 ? 2'b01 : 2'($urandom);
      sub2 = i == 0 ? 1'b1 : 1'($urandom);
      e = ref_op(longint'(a2), longint'(b2), 1'b0, 2);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      lat = 0;
      while (done2 !== 1'b1 && lat < 20) begin tick(); lat++; end
      checks++; if ({ov2, co2, sum2} !== {e[33:32], e[1:0]} || lat != 2) begin
        errors++; $display("FAIL width2 op%0d got %b lat=%0d want %b lat=2", i, {ov2, co2, sum2}, lat, {e[33:32], e[1:0]});
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random(1'b0);
    test_random(1'b1);
    test_back_to_back();
    test_mid_reset();
    test_width2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
